regfile_wr_arb: RTL and testbench
=================================

REGFILE_WR_ARB -- requirements
Module: regfile_wr_arb

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning register data width.
REQ-002 SHALL have parameter NUM_REGS, default 8, meaning register count; select width is log2(NUM_REGS) = 3.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 alu_valid  in  1  ALU writeback request.
REQ-006 alu_dr  in  3  ALU destination register.
REQ-007 alu_data  in  16  ALU result.
REQ-008 alu_ready  out  1  ALU request accepted this cycle when high with alu_valid.
REQ-009 mem_valid  in  1  memory-load writeback request.
REQ-010 mem_dr  in  3  load destination register.
REQ-011 mem_data  in  16  load data (MDR).
REQ-012 mem_ready  out  1  memory request accepted this cycle when high with mem_valid.
REQ-013 dr_sel  out  3  register-file write select, registered.
REQ-014 dr_in  out  16  register-file write data, registered.
REQ-015 load_reg  out  1  register-file write enable, registered.
REQ-016 init_done  out  1  register clear sequence complete.
REQ-017 wr_count  out  16  accepted RUN-state writes, saturating.

Function
REQ-018 SHALL implement states INIT and RUN.
- INIT: clear registers.
- RUN: arbitrate writes.
REQ-019 In INIT, each edge SHALL drive load_reg=1, dr_in=0 and dr_sel=clear counter, then increment the counter.
- Counter 0..7 gives R0..R7 on eight consecutive edges.
REQ-020 On the edge issuing R7, state SHALL become RUN and init_done SHALL become 1.
REQ-021 In INIT, alu_ready and mem_ready SHALL be 0.
REQ-022 In RUN, ready outputs SHALL be combinational:
- alu_ready = !mem_valid || prio==ALU
- mem_ready = !alu_valid || prio==MEM
- Both are high when neither requester is valid.
REQ-023 A transfer SHALL occur when valid && ready.
- At most one transfer per cycle.
- Write latency is 1 cycle: the next edge registers load_reg=1 and the accepted dr/data.
REQ-024 With no transfer in RUN, load_reg SHALL be 0 next cycle; dr_sel and dr_in SHALL hold.
REQ-025 When both requesters are valid in the same cycle, the prio holder SHALL win and prio SHALL toggle.
- Uncontested grants SHALL NOT change prio.
REQ-026 Requesters SHALL hold valid, dr and data stable until accepted; the block does not buffer rejected requests.
REQ-027 wr_count SHALL increment once per RUN transfer and saturate at 0xFFFF.
- INIT writes are not counted.
REQ-028 Simultaneous requests to the same dr SHALL be serialized: the winner writes first and the loser writes on a later cycle, so the loser's data is final.

Reset
REQ-029 rst asserted SHALL immediately force the following, regardless of clock:
- state=INIT, clear counter=0, prio=ALU
- load_reg=0, dr_sel=0, dr_in=0
- init_done=0, wr_count=0
REQ-030 rst asserted mid-INIT or mid-RUN SHALL abort any in-flight write; the clear sequence SHALL restart at R0 on the first edge after release.

Structure
REQ-031 Package lc3_pkg SHALL hold:
- the state enum (INIT, RUN) and the prio enum (ALU, MEM)
- constants REG_W=16, SEL_W=3, NUM_REGS=8
REQ-032 The 2-way round-robin arbiter SHALL be a sub-module rr_arb2:
- inputs: two requests, prio
- outputs: two grants, next prio
REQ-033 The FSM, output registers and counter SHALL reside in regfile_wr_arb.

Verification
REQ-034 Release rst, then 8 idle cycles -> load_reg=1 with dr_sel=0..7 and dr_in=0 on edges 1..8; init_done=1 after edge 8; ready=0 throughout INIT.
REQ-035 RUN, alu_valid only (dr=3, data=0x1234) -> alu_ready=1 in that cycle; next cycle load_reg=1, dr_sel=3, dr_in=0x1234; wr_count=1.
REQ-036 RUN, both valid for 4 cycles (ALU dr=1 data=0xAAAA, MEM dr=2 data=0x5555, each held until accepted, then re-presented) -> grants alternate ALU, MEM, ALU, MEM; prio=ALU at end.
REQ-037 RUN, both valid with same dr=5 (ALU 0x0001, MEM 0x0002), prio=ALU -> writes 0x0001 then 0x0002 on consecutive cycles.
REQ-038 Assert rst mid-INIT (after R3 written) and mid-RUN write -> outputs 0 immediately without a clock edge; after release the clear sequence restarts at R0.
REQ-039 Preload wr_count to 0xFFFE via 0xFFFE writes (or force), then 3 more writes -> wr_count holds 0xFFFF.

Source files
------------

// File: rtl/lc3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lc3_pkg
// Description : Shared types and constants for the register-file write
//               arbiter. Holds the control state type, the arbitration
//               priority type, the register geometry constants and a helper
//               that flips the round-robin priority.
// Revision    : 1.0 - initial release
// ============================================================================
package lc3_pkg;

  localparam int REG_W    = 16;
  localparam int SEL_W    = 3;
  localparam int NUM_REGS = 8;

  // State codes are kept as plain constants so legacy code can compare
  // against raw bit patterns; the enum below reuses the same encodings.
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef enum logic [0:0] {
    INIT = ST_INIT,
    RUN  = ST_RUN
  } state_e;

  typedef enum logic [0:0] {
    ALU = 1'b0,
    MEM = 1'b1
  } prio_e;

  function automatic prio_e prio_flip(input prio_e p);
    return (p == ALU) ? MEM : ALU;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wr_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wr_arb_if
// Description : Writeback request bus between the two requesters (ALU and
//               memory load path) and the register-file write arbiter.
//   alu_valid/alu_dr/alu_data : ALU writeback request       (master -> slave)
//   alu_ready                 : ALU request accepted         (slave -> master)
//   mem_valid/mem_dr/mem_data : load writeback request       (master -> slave)
//   mem_ready                 : load request accepted        (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wr_arb_if
  import lc3_pkg::*;
#(
  parameter int DATA_W = REG_W,
  parameter int SEL_W  = lc3_pkg::SEL_W
);

  logic              alu_valid;
  logic [SEL_W-1:0]  alu_dr;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;

  logic              mem_valid;
  logic [SEL_W-1:0]  mem_dr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;

  modport master (
    output alu_valid, alu_dr, alu_data,
    input  alu_ready,
    output mem_valid, mem_dr, mem_data,
    input  mem_ready
  );

  modport slave (
    input  alu_valid, alu_dr, alu_data,
    output alu_ready,
    input  mem_valid, mem_dr, mem_data,
    output mem_ready
  );

endinterface
`default_nettype wire

// File: rtl/regfile_wr_arb_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter, purely combinational.
//   req0/req1 : requests (0 = ALU, 1 = MEM)
//   prio      : current priority holder
//   gnt0/gnt1 : grants, at most one high
//   prio_nxt  : priority for the next cycle; flips only when both requested
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
  import lc3_pkg::*;
(
  input  logic  req0,
  input  logic  req1,
  input  prio_e prio,
  output logic  gnt0,
  output logic  gnt1,
  output prio_e prio_nxt
);

  logic contested;

  assign contested = req0 && req1;
  assign gnt0      = req0 && (!req1 || prio == ALU);
  assign gnt1      = req1 && (!req0 || prio == MEM);
  // An uncontested grant leaves the turn with whoever already held it.
  assign prio_nxt  = contested ? prio_flip(prio) : prio;

endmodule
`default_nettype wire

// File: rtl/regfile_wr_arb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wr_arb
// Description : Register-file write arbiter. After reset it clears R0..R7 on
//               eight consecutive edges, then arbitrates ALU and memory-load
//               writebacks round-robin, issuing one registered write per cycle.
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : ALU / load writeback requests (slave side)
//   dr_sel     : register-file write select (registered)
//   dr_in      : register-file write data (registered)
//   load_reg   : register-file write enable (registered)
//   init_done  : register clear sequence complete
//   wr_count   : accepted RUN-state writes, saturating at all-ones
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wr_arb #(
  parameter int DATA_W   = lc3_pkg::REG_W,
  parameter int NUM_REGS = lc3_pkg::NUM_REGS
) (
  input  logic                        clk,
  input  logic                        rst,
  regfile_wr_arb_if.slave             bus,
  output logic [$clog2(NUM_REGS)-1:0] dr_sel,
  output logic [DATA_W-1:0]           dr_in,
  output logic                        load_reg,
  output logic                        init_done,
  output logic [15:0]                 wr_count
);
  import lc3_pkg::*;

  localparam int SEL_BITS = $clog2(NUM_REGS);

  state_e              state_q, state_d;
  prio_e               prio_q, prio_d;
  logic [SEL_BITS-1:0] clr_cnt_q, clr_cnt_d;
  logic                load_reg_q, load_reg_d;
  logic [SEL_BITS-1:0] dr_sel_q, dr_sel_d;
  logic [DATA_W-1:0]   dr_in_q, dr_in_d;
  logic                init_done_q, init_done_d;
  logic [15:0]         wr_count_q, wr_count_d;

  logic  run;
  logic  gnt_alu, gnt_mem;
  prio_e prio_arb;

  assign run = (state_q == RUN);

  rr_arb2 u_arb (
    .req0     (bus.alu_valid),
    .req1     (bus.mem_valid),
    .prio     (prio_q),
    .gnt0     (gnt_alu),
    .gnt1     (gnt_mem),
    .prio_nxt (prio_arb)
  );

  // Ready does not depend on the requester's own valid, so an idle requester
  // still sees ready when the other side is not competing for the slot.
  assign bus.alu_ready = run && (!bus.mem_valid || prio_q == ALU);
  assign bus.mem_ready = run && (!bus.alu_valid || prio_q == MEM);

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    clr_cnt_d   = clr_cnt_q;
    load_reg_d  = 1'b0;
    dr_sel_d    = dr_sel_q;
    dr_in_d     = dr_in_q;
    init_done_d = init_done_q;
    wr_count_d  = wr_count_q;

    case (state_q)
      INIT: begin
        load_reg_d = 1'b1;
        dr_sel_d   = clr_cnt_q;
        dr_in_d    = '0;
        clr_cnt_d  = clr_cnt_q + 1'b1;
        if (clr_cnt_q == SEL_BITS'(NUM_REGS - 1)) begin
          state_d     = RUN;
          init_done_d = 1'b1;
          clr_cnt_d   = '0;
        end
      end
      default: begin
        prio_d = prio_arb;
        if (gnt_alu) begin
          dr_sel_d = bus.alu_dr;
          dr_in_d  = bus.alu_data;
        end else if (gnt_mem) begin
          dr_sel_d = bus.mem_dr;
          dr_in_d  = bus.mem_data;
        end
        if (gnt_alu || gnt_mem) begin
          load_reg_d = 1'b1;
          if (wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= INIT;
      prio_q      <= ALU;
      clr_cnt_q   <= '0;
      load_reg_q  <= 1'b0;
      dr_sel_q    <= '0;
      dr_in_q     <= '0;
      init_done_q <= 1'b0;
      wr_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      clr_cnt_q   <= clr_cnt_d;
      load_reg_q  <= load_reg_d;
      dr_sel_q    <= dr_sel_d;
      dr_in_q     <= dr_in_d;
      init_done_q <= init_done_d;
      wr_count_q  <= wr_count_d;
    end
  end

  assign dr_sel    = dr_sel_q;
  assign dr_in     = dr_in_q;
  assign load_reg  = load_reg_q;
  assign init_done = init_done_q;
  assign wr_count  = wr_count_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wr_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wr_arb
// Description : Self-checking bench for regfile_wr_arb: directed vector table,
//               reset/clear sequences, randomized traffic against a
//               behavioural model, and counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wr_arb;
  import lc3_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  dr_sel;
  logic [15:0] dr_in;
  logic        load_reg;
  logic        init_done;
  logic [15:0] wr_count;

  always #5 clk = ~clk;

  regfile_wr_arb_if #(.DATA_W(16), .SEL_W(3)) bus ();

  regfile_wr_arb #(.DATA_W(16), .NUM_REGS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dr_sel    (dr_sel),
    .dr_in     (dr_in),
    .load_reg  (load_reg),
    .init_done (init_done),
    .wr_count  (wr_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic av, input logic [2:0] adr, input logic [15:0] adat,
                        input logic mv, input logic [2:0] mdr, input logic [15:0] mdat);
    bus.alu_valid = av;
    bus.alu_dr    = adr;
    bus.alu_data  = adat;
    bus.mem_valid = mv;
    bus.mem_dr    = mdr;
    bus.mem_data  = mdat;
  endtask

  // Called at posedge+1; checks that everything clears without a clock edge.
  task automatic reset_pulse(input string tag);
    rst = 1'b1;
    #2;
    chk({tag, " rst load_reg"},  32'(load_reg),      32'd0);
    chk({tag, " rst dr_sel"},    32'(dr_sel),        32'd0);
    chk({tag, " rst dr_in"},     32'(dr_in),         32'd0);
    chk({tag, " rst init_done"}, 32'(init_done),     32'd0);
    chk({tag, " rst wr_count"},  32'(wr_count),      32'd0);
    chk({tag, " rst alu_ready"}, 32'(bus.alu_ready), 32'd0);
    chk({tag, " rst mem_ready"}, 32'(bus.mem_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Requests are held during the clear sequence; none may be accepted.
  task automatic init_seq(input int n_edges);
    set_in(1'b1, 3'($urandom_range(0, 7)), 16'($urandom),
           1'b1, 3'($urandom_range(0, 7)), 16'($urandom));
    for (int e = 0; e < n_edges; e++) begin
      @(negedge clk);
      chk($sformatf("init%0d alu_ready", e), 32'(bus.alu_ready), 32'd0);
      chk($sformatf("init%0d mem_ready", e), 32'(bus.mem_ready), 32'd0);
      @(posedge clk); #1;
      chk($sformatf("init%0d load_reg", e),  32'(load_reg),  32'd1);
      chk($sformatf("init%0d dr_sel", e),    32'(dr_sel),    32'(e));
      chk($sformatf("init%0d dr_in", e),     32'(dr_in),     32'd0);
      chk($sformatf("init%0d init_done", e), 32'(init_done), (e == 7) ? 32'd1 : 32'd0);
      chk($sformatf("init%0d wr_count", e),  32'(wr_count),  32'd0);
    end
    set_in(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0);
  endtask

  typedef struct {
    logic        av;
    logic [2:0]  adr;
    logic [15:0] adat;
    logic        mv;
    logic [2:0]  mdr;
    logic [15:0] mdat;
    logic        e_ard;
    logic        e_mrd;
    logic        e_load;
    logic [2:0]  e_sel;
    logic [15:0] e_din;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vt[13];

  // Randomized-phase requesters and reference model state.
  logic        alu_pend, mem_pend;
  logic [2:0]  alu_dr_r, mem_dr_r;
  logic [15:0] alu_dat_r, mem_dat_r;
  bit          turn_mem;
  int          m_cnt;
  logic [2:0]  m_sel;
  logic [15:0] m_din;
  bit          m_load;

  initial begin
    //        av   adr   adat      mv   mdr   mdat     ard  mrd  load sel  din       cnt
    vt[0]  = '{1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd3, 16'h1234, 16'd1};
    vt[1]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 3'd3, 16'h1234, 16'd1};
    vt[2]  = '{1'b1, 3'd1, 16'hAAAA, 1'b1, 3'd2, 16'h5555, 1'b1, 1'b0, 1'b1, 3'd1, 16'hAAAA, 16'd2};
    vt[3]  = '{1'b1, 3'd1, 16'hAAAA, 1'b1, 3'd2, 16'h5555, 1'b0, 1'b1, 1'b1, 3'd2, 16'h5555, 16'd3};
    vt[4]  = '{1'b1, 3'd1, 16'hAAAA, 1'b1, 3'd2, 16'h5555, 1'b1, 1'b0, 1'b1, 3'd1, 16'hAAAA, 16'd4};
    vt[5]  = '{1'b1, 3'd1, 16'hAAAA, 1'b1, 3'd2, 16'h5555, 1'b0, 1'b1, 1'b1, 3'd2, 16'h5555, 16'd5};
    vt[6]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd6, 16'hBEEF, 1'b1, 1'b1, 1'b1, 3'd6, 16'hBEEF, 16'd6};
    vt[7]  = '{1'b1, 3'd5, 16'h0001, 1'b1, 3'd5, 16'h0002, 1'b1, 1'b0, 1'b1, 3'd5, 16'h0001, 16'd7};
    vt[8]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 16'h0002, 1'b0, 1'b1, 1'b1, 3'd5, 16'h0002, 16'd8};
    vt[9]  = '{1'b1, 3'd0, 16'h00FF, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 1'b1, 3'd0, 16'h00FF, 16'd9};
    vt[10] = '{1'b1, 3'd7, 16'h7777, 1'b1, 3'd4, 16'h4444, 1'b0, 1'b1, 1'b1, 3'd4, 16'h4444, 16'd10};
    vt[11] = '{1'b1, 3'd7, 16'h7777, 1'b1, 3'd4, 16'h4444, 1'b1, 1'b0, 1'b1, 3'd7, 16'h7777, 16'd11};
    vt[12] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 3'd7, 16'h7777, 16'd11};

    rst = 1'b1;
    set_in(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0);
    @(posedge clk); #1;
    chk("por load_reg",  32'(load_reg),  32'd0);
    chk("por dr_sel",    32'(dr_sel),    32'd0);
    chk("por dr_in",     32'(dr_in),     32'd0);
    chk("por init_done", 32'(init_done), 32'd0);
    chk("por wr_count",  32'(wr_count),  32'd0);
    rst = 1'b0;

    // Reset in the middle of the clear sequence, right after R3 is issued.
    init_seq(4);
    reset_pulse("midinit");
    init_seq(8);

    // Directed vector table, starting from a fresh RUN state.
    for (int i = 0; i < 13; i++) begin
      set_in(vt[i].av, vt[i].adr, vt[i].adat, vt[i].mv, vt[i].mdr, vt[i].mdat);
      @(negedge clk);
      chk($sformatf("vec%0d alu_ready", i), 32'(bus.alu_ready), 32'(vt[i].e_ard));
      chk($sformatf("vec%0d mem_ready", i), 32'(bus.mem_ready), 32'(vt[i].e_mrd));
      @(posedge clk); #1;
      chk($sformatf("vec%0d load_reg", i), 32'(load_reg), 32'(vt[i].e_load));
      chk($sformatf("vec%0d dr_sel", i),   32'(dr_sel),   32'(vt[i].e_sel));
      chk($sformatf("vec%0d dr_in", i),    32'(dr_in),    32'(vt[i].e_din));
      chk($sformatf("vec%0d wr_count", i), 32'(wr_count), 32'(vt[i].e_cnt));
    end

    // Reset right after a RUN write lands.
    set_in(1'b1, 3'd2, 16'hCAFE, 1'b0, 3'd0, 16'd0);
    @(posedge clk); #1;
    chk("midrun load_reg", 32'(load_reg), 32'd1);
    chk("midrun dr_sel",   32'(dr_sel),   32'd2);
    chk("midrun dr_in",    32'(dr_in),    32'hCAFE);
    chk("midrun wr_count", 32'(wr_count), 32'd12);
    reset_pulse("midrun");
    init_seq(8);

    // Randomized traffic against the reference model.
    alu_pend = 1'b0; mem_pend = 1'b0;
    alu_dr_r = '0; mem_dr_r = '0; alu_dat_r = '0; mem_dat_r = '0;
    turn_mem = 1'b0; m_cnt = 0;
    for (int c = 0; c < 600; c++) begin
      int winner;
      if (!alu_pend && $urandom_range(0, 2) != 0) begin
        alu_pend  = 1'b1;
        alu_dr_r  = 3'($urandom_range(0, 7));
        alu_dat_r = 16'($urandom);
      end
      if (!mem_pend && $urandom_range(0, 2) != 0) begin
        mem_pend  = 1'b1;
        mem_dr_r  = 3'($urandom_range(0, 7));
        mem_dat_r = 16'($urandom);
      end
      set_in(alu_pend, alu_dr_r, alu_dat_r, mem_pend, mem_dr_r, mem_dat_r);

      // A requester is turned away only when the other side is also asking
      // and it is the other side's turn.
      @(negedge clk);
      chk($sformatf("rnd%0d alu_ready", c), 32'(bus.alu_ready), (mem_pend && turn_mem) ? 32'd0 : 32'd1);
      chk($sformatf("rnd%0d mem_ready", c), 32'(bus.mem_ready), (alu_pend && !turn_mem) ? 32'd0 : 32'd1);

      winner = 0;
      if (alu_pend && mem_pend) begin
        winner   = turn_mem ? 2 : 1;
        turn_mem = !turn_mem;
      end else if (alu_pend) begin
        winner = 1;
      end else if (mem_pend) begin
        winner = 2;
      end
      m_load = (winner != 0);
      if (winner == 1) begin
        m_sel = alu_dr_r; m_din = alu_dat_r; alu_pend = 1'b0;
      end else if (winner == 2) begin
        m_sel = mem_dr_r; m_din = mem_dat_r; mem_pend = 1'b0;
      end
      if (winner != 0 && m_cnt < 65535) m_cnt++;

      @(posedge clk); #1;
      chk($sformatf("rnd%0d load_reg", c), 32'(load_reg), 32'(m_load));
      if (m_load) begin
        chk($sformatf("rnd%0d dr_sel", c), 32'(dr_sel), 32'(m_sel));
        chk($sformatf("rnd%0d dr_in", c),  32'(dr_in),  32'(m_din));
      end
      chk($sformatf("rnd%0d wr_count", c), 32'(wr_count), 32'(m_cnt));
    end

    // Counter saturation: one accepted ALU write per cycle from zero.
    reset_pulse("sat");
    init_seq(8);
    set_in(1'b1, 3'd1, 16'h0F0F, 1'b0, 3'd0, 16'd0);
    repeat (65534) @(posedge clk);
    #1;
    chk("sat wr_count 0xFFFE", 32'(wr_count), 32'hFFFE);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("sat wr_count +%0d", k + 1), 32'(wr_count), 32'hFFFF);
    end
    set_in(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
